// File: rtl/id_issue_queue_if.sv
// rtl/id_issue_queue_if.sv - fetch/issue handshake bundle for the instruction issue queue
interface id_issue_queue_if #(
   parameter int DEPTH       = 8,
   parameter int FETCH_WIDTH = 2,
   parameter int ISSUE_WIDTH = 2
);
   logic [FETCH_WIDTH-1:0]    fetch_valid_i;
   logic [32*FETCH_WIDTH-1:0] fetch_instr_i;
   logic [32*FETCH_WIDTH-1:0] fetch_pc_i;
   logic                      fetch_ready_o;
   logic                      issue_ready_i;
   logic [ISSUE_WIDTH-1:0]    issue_valid_o;
   logic [32*ISSUE_WIDTH-1:0] issue_instr_o;
   logic [32*ISSUE_WIDTH-1:0] issue_pc_o;
   logic [3*ISSUE_WIDTH-1:0]  issue_class_o;
   logic [5*ISSUE_WIDTH-1:0]  issue_dst_o;
   logic [$clog2(DEPTH):0]    count_o;

   // Fetch/decode side: drives instructions in, consumes issue slots
   modport master (
      output fetch_valid_i, fetch_instr_i, fetch_pc_i, issue_ready_i,
      input  fetch_ready_o, issue_valid_o, issue_instr_o, issue_pc_o,
      input  issue_class_o, issue_dst_o, count_o
   );

   // Queue side
   modport slave (
      input  fetch_valid_i, fetch_instr_i, fetch_pc_i, issue_ready_i,
      output fetch_ready_o, issue_valid_o, issue_instr_o, issue_pc_o,
      output issue_class_o, issue_dst_o, count_o
   );
endinterface

// File: rtl/id_issue_queue.sv
// rtl/id_issue_queue.sv - instruction buffer with pre-decode and dual-issue pairing
module id_issue_queue #(
   parameter int DEPTH       = 8,
   parameter int FETCH_WIDTH = 2,
   parameter int ISSUE_WIDTH = 2
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            flush_i,
   id_issue_queue_if.slave q
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [2:0] C_ALU  = 3'd0;
   localparam logic [2:0] C_BRJ  = 3'd1;
   localparam logic [2:0] C_MEM  = 3'd2;
   localparam logic [2:0] C_HILO = 3'd3;
   localparam logic [2:0] C_CP0  = 3'd4;
   localparam logic [2:0] C_PRIV = 3'd5;
   localparam logic [2:0] C_INV  = 3'd7;

   localparam logic [CW-1:0] PUSH_LIMIT = CW'(DEPTH - FETCH_WIDTH);

   // Returns {class[2:0], dst[4:0]} for one MIPS32 instruction.
   function automatic logic [7:0] predecode(input logic [5:0] op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [5:0] fn);
      logic [2:0] c;
      logic [4:0] d;
      c = C_INV;
      d = 5'd0;
      case (op)
         6'h00: case (fn)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0A, 6'h0B,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B:                         begin c = C_ALU;  d = rd; end
            6'h0F:                                c = C_ALU;
            6'h08:                                c = C_BRJ;
            6'h09:                                begin c = C_BRJ;  d = rd; end
            6'h0C, 6'h0D, 6'h30, 6'h31, 6'h32,
            6'h33, 6'h34, 6'h36:                  c = C_PRIV;
            6'h10, 6'h12:                         begin c = C_HILO; d = rd; end
            6'h11, 6'h13, 6'h18, 6'h19, 6'h1A,
            6'h1B:                                c = C_HILO;
            default:                              c = C_INV;
         endcase
         6'h01: case (rt)
            5'h00, 5'h01, 5'h02, 5'h03:           c = C_BRJ;
            5'h10, 5'h11, 5'h12, 5'h13:           begin c = C_BRJ; d = 5'd31; end
            5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C,
            5'h0E:                                c = C_PRIV;
            default:                              c = C_INV;
         endcase
         6'h02, 6'h04, 6'h05, 6'h06, 6'h07:       c = C_BRJ;
         6'h03:                                   begin c = C_BRJ; d = 5'd31; end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
         6'h0E, 6'h0F:                            begin c = C_ALU; d = rt; end
         6'h10: begin
            if (rs == 5'h00) begin
               c = C_CP0;
               d = rt;
            end else if (rs == 5'h04) begin
               c = C_CP0;
            end else if (rs[4]) begin
               case (fn)
                  6'h01, 6'h02, 6'h06, 6'h08:     c = C_CP0;
                  6'h18:                          c = C_PRIV;
                  default:                        c = C_INV;
               endcase
            end
         end
         6'h1C: case (fn)
            6'h00, 6'h01, 6'h04, 6'h05:           c = C_HILO;
            6'h02, 6'h20, 6'h21:                  begin c = C_HILO; d = rd; end
            default:                              c = C_INV;
         endcase
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
         6'h26, 6'h30, 6'h38:                     begin c = C_MEM; d = rt; end
         6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E:       c = C_MEM;
         6'h2F:                                   c = C_ALU;
         default:                                 c = C_INV;
      endcase
      return {c, d};
   endfunction

   // Classes that must never share an issue cycle with another instruction
   function automatic logic solo_class(input logic [2:0] c);
      return (c == C_BRJ) || (c == C_CP0) || (c == C_PRIV) || (c == C_INV);
   endfunction

   logic [31:0]  ent_instr [DEPTH];
   logic [31:0]  ent_pc    [DEPTH];
   logic [2:0]   ent_cls   [DEPTH];
   logic [4:0]   ent_dst   [DEPTH];

   logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr1;
   logic [CW-1:0] count, n_push, n_pop;
   logic          fetch_ready, push, pair_ok;
   logic [7:0]    lane_dec [FETCH_WIDTH];
   logic [ISSUE_WIDTH-1:0] issue_valid;

   // Ready depends only on current occupancy so fetch never sees a pop-to-push path
   assign fetch_ready = (count <= PUSH_LIMIT);
   assign push        = fetch_ready & q.fetch_valid_i[0] & ~flush_i;
   assign rd_ptr1     = rd_ptr + PW'(1);

   // Pre-decode every fetch lane
   always_comb begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         lane_dec[k] = predecode(q.fetch_instr_i[32*k+26 +: 6], q.fetch_instr_i[32*k+21 +: 5],
                                 q.fetch_instr_i[32*k+16 +: 5], q.fetch_instr_i[32*k+11 +: 5],
                                 q.fetch_instr_i[32*k +: 6]);
      end
   end

   // Number of lanes written this cycle (lane 0 gates the whole group)
   always_comb begin
      n_push = '0;
      if (push) begin
         for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (q.fetch_valid_i[k]) n_push = n_push + CW'(1);
         end
      end
   end

   // Entry storage, written at enqueue with the pre-decoded class and destination
   always_ff @(posedge clk) begin
      if (push) begin
         for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (q.fetch_valid_i[k]) begin
               ent_instr[wr_ptr + PW'(k)] <= q.fetch_instr_i[32*k +: 32];
               ent_pc[wr_ptr + PW'(k)]    <= q.fetch_pc_i[32*k +: 32];
               ent_cls[wr_ptr + PW'(k)]   <= lane_dec[k][7:5];
               ent_dst[wr_ptr + PW'(k)]   <= lane_dec[k][4:0];
            end
         end
      end
   end

   // Pairing rules between the two head entries
   always_comb begin
      pair_ok = 1'b1;
      if (solo_class(ent_cls[rd_ptr]) || solo_class(ent_cls[rd_ptr1])) pair_ok = 1'b0;
      if (ent_cls[rd_ptr] == C_MEM && ent_cls[rd_ptr1] == C_MEM) pair_ok = 1'b0;
      if (ent_cls[rd_ptr] == C_HILO && ent_cls[rd_ptr1] == C_HILO) pair_ok = 1'b0;
      if (ent_dst[rd_ptr] != 5'd0 &&
          (ent_instr[rd_ptr1][25:21] == ent_dst[rd_ptr] ||
           ent_instr[rd_ptr1][20:16] == ent_dst[rd_ptr])) pair_ok = 1'b0;
   end

   generate
      if (ISSUE_WIDTH == 2) begin : g_dual
         assign issue_valid = {pair_ok && (count >= CW'(2)), count != '0};
      end else begin : g_single
         assign issue_valid = (count != '0);
      end
   endgenerate

   // Head slots are read straight from storage; pop count follows the valid slots
   always_comb begin
      n_pop           = '0;
      q.issue_instr_o = '0;
      q.issue_pc_o    = '0;
      q.issue_class_o = '0;
      q.issue_dst_o   = '0;
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
         q.issue_instr_o[32*s +: 32] = ent_instr[rd_ptr + PW'(s)];
         q.issue_pc_o[32*s +: 32]    = ent_pc[rd_ptr + PW'(s)];
         q.issue_class_o[3*s +: 3]   = ent_cls[rd_ptr + PW'(s)];
         q.issue_dst_o[5*s +: 5]     = ent_dst[rd_ptr + PW'(s)];
         if (q.issue_ready_i && issue_valid[s]) n_pop = n_pop + CW'(1);
      end
   end

   // Pointers and occupancy; flush wins over push and pop
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + n_push[PW-1:0];
         rd_ptr <= rd_ptr + n_pop[PW-1:0];
         count  <= count + n_push - n_pop;
      end
   end

   assign q.fetch_ready_o = fetch_ready;
   assign q.issue_valid_o = issue_valid;
   assign q.count_o       = count;
endmodule

// File: tb/tb_id_issue_queue.sv
// tb/tb_id_issue_queue.sv - scoreboard bench for id_issue_queue
module tb_id_issue_queue;
   localparam int DEPTH = 8;
   localparam int FW    = 2;
   localparam int IW    = 2;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [2:0]  cls;
      logic [4:0]  dst;
      int          slot;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic flush_i = 1'b0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic [31:0] pc_next = 32'h1000;

   always #5 clk = ~clk;

   id_issue_queue_if #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW)) bus ();

   id_issue_queue #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW)) dut (
      .clk(clk), .resetn(resetn), .flush_i(flush_i), .q(bus)
   );

   function automatic logic [31:0] r_op(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] v, input logic acc,
                       input logic [31:0] i0, input logic [2:0] c0, input logic [4:0] d0, input int s0,
                       input logic [31:0] i1, input logic [2:0] c1, input logic [4:0] d1, input int s1);
      exp_t e;
      bus.fetch_valid_i = v;
      bus.fetch_instr_i = {i1, i0};
      bus.fetch_pc_i    = {pc_next + 32'd4, pc_next};
      if (acc && v[0]) begin
         e.instr = i0; e.pc = pc_next; e.cls = c0; e.dst = d0; e.slot = s0;
         sb.push_back(e);
         if (v[1]) begin
            e.instr = i1; e.pc = pc_next + 32'd4; e.cls = c1; e.dst = d1; e.slot = s1;
            sb.push_back(e);
         end
      end
      pc_next = pc_next + 32'd8;
      @(negedge clk);
      check("fetch_ready_at_push", bus.fetch_ready_o, acc);
      step();
      bus.fetch_valid_i = '0;
   endtask

   task automatic drain();
      int n = 0;
      bus.issue_ready_i = 1'b1;
      @(negedge clk);
      while (bus.count_o != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("drain_count", bus.count_o, 0);
      check("scoreboard_empty", sb.size(), 0);
      step();
      bus.issue_ready_i = 1'b0;
   endtask

   // Monitor: every consumed slot is compared against the oldest expected entry
   always @(negedge clk) begin
      if (resetn && bus.issue_ready_i) begin
         if (bus.issue_valid_o[1]) check("slot1_needs_slot0", bus.issue_valid_o[0], 1'b1);
         for (int s = 0; s < IW; s++) begin
            if (bus.issue_valid_o[s]) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_issue: slot %0d instr %0h with empty scoreboard",
                           s, bus.issue_instr_o[32*s +: 32]);
               end else begin
                  mon_e = sb.pop_front();
                  check("issue_instr", bus.issue_instr_o[32*s +: 32], mon_e.instr);
                  check("issue_pc", bus.issue_pc_o[32*s +: 32], mon_e.pc);
                  check("issue_class", bus.issue_class_o[3*s +: 3], mon_e.cls);
                  check("issue_dst", bus.issue_dst_o[5*s +: 5], mon_e.dst);
                  check("issue_slot", s, mon_e.slot);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      logic [31:0] addu3, ori4, subu6, beq, lw2, lw5, sw7, inv, sysc, eret, addu10;
      logic [31:0] jal, mfc0, mult, mflo, lw8, bgezal;
      addu3  = r_op(6'h21, 5'd1, 5'd2, 5'd3);
      ori4   = i_op(6'h0D, 5'd5, 5'd4, 16'd7);
      subu6  = r_op(6'h23, 5'd3, 5'd4, 5'd6);
      beq    = i_op(6'h04, 5'd1, 5'd2, 16'h10);
      lw2    = i_op(6'h23, 5'd1, 5'd2, 16'd0);
      lw5    = i_op(6'h23, 5'd6, 5'd5, 16'd4);
      sw7    = i_op(6'h2B, 5'd8, 5'd7, 16'd8);
      inv    = {6'h3F, 26'd0};
      sysc   = r_op(6'h0C, 5'd0, 5'd0, 5'd0);
      eret   = 32'h4200_0018;
      addu10 = r_op(6'h21, 5'd1, 5'd2, 5'd10);
      jal    = {6'h03, 26'h100};
      mfc0   = {6'h10, 5'h00, 5'd9, 5'd12, 11'd0};
      mult   = r_op(6'h18, 5'd1, 5'd2, 5'd0);
      mflo   = r_op(6'h12, 5'd0, 5'd0, 5'd7);
      lw8    = i_op(6'h23, 5'd9, 5'd8, 16'd0);
      bgezal = {6'h01, 5'd4, 5'h11, 16'h8};

      bus.fetch_valid_i = '0;
      bus.fetch_instr_i = '0;
      bus.fetch_pc_i    = '0;
      bus.issue_ready_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_count", bus.count_o, 0);
      check("reset_issue_valid", bus.issue_valid_o, 0);
      check("reset_fetch_ready", bus.fetch_ready_o, 1);
      step();
      resetn = 1'b1;
      step();

      // Independent ALU pair issues together, then one pop cycle empties the queue
      push(2'b11, 1, addu3, 3'd0, 5'd3, 0, ori4, 3'd0, 5'd4, 1);
      @(negedge clk);
      check("t1_issue_valid", bus.issue_valid_o, 2'b11);
      check("t1_class", bus.issue_class_o, {3'd0, 3'd0});
      check("t1_dst", bus.issue_dst_o, {5'd4, 5'd3});
      check("t1_count", bus.count_o, 2);
      step();
      bus.issue_ready_i = 1'b1;
      step();
      bus.issue_ready_i = 1'b0;
      @(negedge clk);
      check("t1_count_after_pop", bus.count_o, 0);
      step();

      // RAW hazard on $3 splits the pair
      push(2'b11, 1, addu3, 3'd0, 5'd3, 0, subu6, 3'd0, 5'd6, 0);
      @(negedge clk);
      check("t2_issue_valid", bus.issue_valid_o, 2'b01);
      step();
      drain();

      // Branch issues alone; back-to-back memory ops issue singly
      push(2'b11, 1, beq, 3'd1, 5'd0, 0, lw2, 3'd2, 5'd2, 0);
      push(2'b11, 1, lw5, 3'd2, 5'd5, 0, sw7, 3'd2, 5'd0, 0);
      @(negedge clk);
      check("t3_issue_valid", bus.issue_valid_o, 2'b01);
      check("t3_count", bus.count_o, 4);
      step();
      drain();

      // Invalid and privileged instructions
      push(2'b11, 1, inv, 3'd7, 5'd0, 0, sysc, 3'd5, 5'd0, 0);
      push(2'b11, 1, eret, 3'd5, 5'd0, 0, addu10, 3'd0, 5'd10, 0);
      @(negedge clk);
      check("t5_issue_valid", bus.issue_valid_o, 2'b01);
      check("t5_head_class", bus.issue_class_o[2:0], 3'd7);
      step();
      drain();

      // Link registers, CP0, HI/LO pairing
      push(2'b11, 1, jal, 3'd1, 5'd31, 0, mfc0, 3'd4, 5'd9, 0);
      push(2'b11, 1, mult, 3'd3, 5'd0, 0, mflo, 3'd3, 5'd7, 0);
      push(2'b11, 1, lw8, 3'd2, 5'd8, 1, addu10, 3'd0, 5'd10, 0);
      push(2'b11, 1, bgezal, 3'd1, 5'd31, 0, ori4, 3'd0, 5'd4, 0);
      @(negedge clk);
      check("t6_count", bus.count_o, 8);
      step();
      drain();

      // Fill to DEPTH, reject one push, then pop+push across the wrap point
      for (int n = 0; n < 4; n++) begin
         push(2'b11, 1, r_op(6'h21, 5'd1, 5'd2, 5'(10 + 2*n)), 3'd0, 5'(10 + 2*n), 0,
                        r_op(6'h21, 5'd1, 5'd2, 5'(11 + 2*n)), 3'd0, 5'(11 + 2*n), 1);
      end
      @(negedge clk);
      check("t4_full_count", bus.count_o, 8);
      check("t4_full_ready", bus.fetch_ready_o, 0);
      step();
      push(2'b11, 0, addu3, 3'd0, 5'd3, 0, ori4, 3'd0, 5'd4, 1);
      @(negedge clk);
      check("t4_reject_count", bus.count_o, 8);
      step();
      bus.issue_ready_i = 1'b1;
      step();
      bus.issue_ready_i = 1'b0;
      @(negedge clk);
      check("t4_after_pop2", bus.count_o, 6);
      step();
      bus.issue_ready_i = 1'b1;
      push(2'b11, 1, r_op(6'h21, 5'd1, 5'd2, 5'd18), 3'd0, 5'd18, 0,
                     r_op(6'h21, 5'd1, 5'd2, 5'd19), 3'd0, 5'd19, 1);
      bus.issue_ready_i = 1'b0;
      @(negedge clk);
      check("t4_pop_push_count", bus.count_o, 6);
      step();
      drain();

      // Lone lane 1 is ignored; flush beats a concurrent push
      push(2'b11, 1, addu3, 3'd0, 5'd3, 0, ori4, 3'd0, 5'd4, 1);
      push(2'b11, 1, addu10, 3'd0, 5'd10, 0, ori4, 3'd0, 5'd4, 1);
      push(2'b01, 1, addu3, 3'd0, 5'd3, 0, ori4, 3'd0, 5'd4, 1);
      push(2'b10, 1, addu3, 3'd0, 5'd3, 0, ori4, 3'd0, 5'd4, 1);
      @(negedge clk);
      check("t7_lane1_only_count", bus.count_o, 5);
      step();
      flush_i = 1'b1;
      bus.fetch_valid_i = 2'b11;
      bus.fetch_instr_i = {ori4, addu3};
      step();
      flush_i = 1'b0;
      bus.fetch_valid_i = '0;
      sb.delete();
      @(negedge clk);
      check("t7_flush_count", bus.count_o, 0);
      check("t7_flush_valid", bus.issue_valid_o, 0);
      check("t7_flush_ready", bus.fetch_ready_o, 1);
      step();

      // Asynchronous reset in the middle of a cycle
      push(2'b11, 1, addu3, 3'd0, 5'd3, 0, ori4, 3'd0, 5'd4, 1);
      push(2'b11, 1, addu10, 3'd0, 5'd10, 0, ori4, 3'd0, 5'd4, 1);
      #2;
      resetn = 1'b0;
      #1;
      check("t8_reset_count", bus.count_o, 0);
      check("t8_reset_valid", bus.issue_valid_o, 0);
      check("t8_reset_ready", bus.fetch_ready_o, 1);
      sb.delete();
      step();
      resetn = 1'b1;
      step();

      // Queue works normally after reset
      push(2'b11, 1, addu3, 3'd0, 5'd3, 0, ori4, 3'd0, 5'd4, 1);
      step();
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
